// File: rtl/calc_pkg.sv
// Shared constants for the calculator core: op codes, button indices, FSM states.
package calc_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_AND   = 3'd4;
  localparam logic [2:0] OP_OR    = 3'd5;
  localparam logic [2:0] OP_XOR   = 3'd6;
  localparam logic [2:0] OP_PASSB = 3'd7;

  localparam int unsigned BTN_EXEC   = 0;
  localparam int unsigned BTN_NEXT   = 1;
  localparam int unsigned BTN_RECALL = 2;
  localparam int unsigned BTN_CLEAR  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StExec,
    StDone
  } state_e;

endpackage

// File: rtl/calc_muldiv.sv
// Iterative magnitude multiplier (shift-add) / restoring divider with sign fix-up.
// Runs DataW iterations after start; done_o is high in the last iteration cycle and
// res_o then already reflects that final iteration.
module calc_muldiv #(
  parameter int unsigned DataW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 div_i,
  input  logic                 sgn_i,
  input  logic [DataW-1:0]     a_i,
  input  logic [DataW-1:0]     b_i,
  output logic                 done_o,
  output logic [2*DataW-1:0]   res_o,
  output logic                 dz_o,
  output logic                 qovf_o
);

  localparam int unsigned ResW = 2 * DataW;
  localparam int unsigned CntW = $clog2(DataW);

  logic             run_q, div_q, sgn_q, neg_q, rneg_q, dz_q;
  logic [CntW-1:0]  cnt_q;
  // Mul: p = partial product, x = shifted multiplicand, y = multiplier.
  // Div: p = remainder, x = divisor, y = dividend shifting into quotient.
  logic [ResW-1:0]  p_q, x_q, p_d, x_d;
  logic [DataW-1:0] y_q, y_d;
  logic [DataW-1:0] a_mag, b_mag, q_s, r_s;
  logic [DataW:0]   sh, diff;
  logic             last;

  assign a_mag = (sgn_i && a_i[DataW-1]) ? -a_i : a_i;
  assign b_mag = (sgn_i && b_i[DataW-1]) ? -b_i : b_i;

  // One shift-add or restoring-subtract step.
  always_comb begin
    p_d  = p_q;
    x_d  = x_q;
    y_d  = y_q;
    sh   = {p_q[DataW-1:0], y_q[DataW-1]};
    diff = sh - x_q[DataW:0];
    if (div_q) begin
      y_d = {y_q[DataW-2:0], 1'b0};
      if (sh >= x_q[DataW:0]) begin
        p_d    = {{(DataW-1){1'b0}}, diff};
        y_d[0] = 1'b1;
      end else begin
        p_d = {{(DataW-1){1'b0}}, sh};
      end
    end else begin
      if (y_q[0]) p_d = p_q + x_q;
      x_d = {x_q[ResW-2:0], 1'b0};
      y_d = {1'b0, y_q[DataW-1:1]};
    end
  end

  assign last   = (cnt_q == CntW'(DataW - 1));
  assign done_o = run_q && (dz_q || last);
  assign dz_o   = dz_q;
  // Signed quotient of +2^(W-1) (e.g. -8 / -1) cannot be represented.
  assign qovf_o = div_q && !dz_q && sgn_q && !neg_q && y_d[DataW-1];

  // Apply result signs to the final magnitudes.
  always_comb begin
    q_s = neg_q ? -y_d : y_d;
    r_s = rneg_q ? -p_d[DataW-1:0] : p_d[DataW-1:0];
    if (!div_q) begin
      res_o = neg_q ? -p_d : p_d;
    end else if (dz_q) begin
      res_o = '1;
    end else begin
      res_o = {r_s, q_s};
    end
  end

  // Operand capture on start, then one iteration per cycle until done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= 1'b0;
      div_q  <= 1'b0;
      sgn_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      cnt_q  <= '0;
      p_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else if (abort_i) begin
      run_q <= 1'b0;
    end else if (start_i) begin
      run_q  <= 1'b1;
      div_q  <= div_i;
      sgn_q  <= sgn_i;
      neg_q  <= sgn_i & (a_i[DataW-1] ^ b_i[DataW-1]);
      rneg_q <= sgn_i & a_i[DataW-1];
      dz_q   <= div_i && (b_i == '0);
      cnt_q  <= '0;
      p_q    <= '0;
      if (div_i) begin
        x_q <= {{DataW{1'b0}}, b_mag};
        y_q <= a_mag;
      end else begin
        x_q <= {{DataW{1'b0}}, a_mag};
        y_q <= b_mag;
      end
    end else if (run_q) begin
      p_q   <= p_d;
      x_q   <= x_d;
      y_q   <= y_d;
      cnt_q <= cnt_q + CntW'(1);
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_engine.sv
// Calculator core: op select, operand latch, FSM, sticky flags, accumulator
// chaining and a result-history ring with recall.
module calc_engine
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned HIST_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*DATA_W-1:0]   sw_i,
  input  logic [3:0]            btn_i,
  input  logic                  chain_i,
  input  logic                  sign_i,
  output logic [2:0]            op_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  err_o,
  output logic                  ovf_o,
  output logic                  led_o
);

  localparam int unsigned ResW = 2 * DATA_W;
  localparam int unsigned PtrW = $clog2(HIST_DEPTH);
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(HIST_DEPTH);
  localparam logic [PtrW:0] CntOne  = (PtrW + 1)'(1);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d, lop_q;
  logic [DATA_W-1:0]   a_q, b_q, a_load, b_load;
  logic                sgn_q;
  logic [ResW-1:0]     acc_q, acc_d, result_q, result_d;
  logic                err_q, err_d, ovf_q, ovf_d;
  logic [ResW-1:0]     hist_q [HIST_DEPTH];
  logic [ResW-1:0]     hist_d [HIST_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, k_q, k_d, rec_idx;
  logic [PtrW:0]       cnt_q, cnt_d;

  logic                clear, is_md, fin, md_start, md_done, md_dz, md_qovf, new_ovf, new_err;
  logic [ResW-1:0]     md_res, exec_res, sum_ext;
  logic [DATA_W:0]     a_x, b_x, sum;

  function automatic logic fits_w(input logic [ResW-1:0] v, input logic s);
    if (s) return (&v[ResW-1:DATA_W-1]) | ~(|v[ResW-1:DATA_W-1]);
    return ~(|v[ResW-1:DATA_W]);
  endfunction

  assign clear    = btn_i[BTN_CLEAR];
  assign a_load   = chain_i ? acc_q[DATA_W-1:0] : sw_i[ResW-1:DATA_W];
  assign b_load   = sw_i[DATA_W-1:0];
  assign is_md    = (lop_q == OP_MUL) || (lop_q == OP_DIV);
  assign fin      = (state_q == StExec) && (!is_md || md_done);
  assign md_start = (state_q == StLoad) && !clear && ((op_q == OP_MUL) || (op_q == OP_DIV));
  assign new_err  = (lop_q == OP_DIV) && md_dz;
  assign new_ovf  = (lop_q == OP_DIV) ? md_qovf : !fits_w(exec_res, sgn_q);
  assign rec_idx  = wr_ptr_q - PtrW'(1) - k_q;

  calc_muldiv #(
    .DataW (DATA_W)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_i (md_start),
    .abort_i (clear),
    .div_i   (op_q == OP_DIV),
    .sgn_i   (sign_i),
    .a_i     (a_load),
    .b_i     (b_load),
    .done_o  (md_done),
    .res_o   (md_res),
    .dz_o    (md_dz),
    .qovf_o  (md_qovf)
  );

  // Single-cycle ops; ADD/SUB use a W+1-bit sum extended per sign mode.
  always_comb begin
    a_x     = {sgn_q & a_q[DATA_W-1], a_q};
    b_x     = {sgn_q & b_q[DATA_W-1], b_q};
    sum     = (lop_q == OP_SUB) ? (a_x - b_x) : (a_x + b_x);
    sum_ext = {{(DATA_W-1){sgn_q & sum[DATA_W]}}, sum};
    case (lop_q)
      OP_ADD, OP_SUB: exec_res = sum_ext;
      OP_AND:         exec_res = {{DATA_W{1'b0}}, a_q & b_q};
      OP_OR:          exec_res = {{DATA_W{1'b0}}, a_q | b_q};
      OP_XOR:         exec_res = {{DATA_W{1'b0}}, a_q ^ b_q};
      OP_PASSB:       exec_res = {{DATA_W{1'b0}}, b_q};
      default:        exec_res = md_res;
    endcase
  end

  // FSM next state plus result, accumulator, flag and history updates.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    result_d = result_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    hist_d   = hist_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    case (state_q)
      StIdle: begin
        if (btn_i[BTN_EXEC]) begin
          state_d = StLoad;
          k_d     = '0;
        end else begin
          if (btn_i[BTN_NEXT]) op_d = op_q + 3'd1;
          if (btn_i[BTN_RECALL] && (cnt_q != '0)) begin
            result_d = hist_q[rec_idx];
            k_d      = (({1'b0, k_q} + CntOne) == cnt_q) ? '0 : k_q + PtrW'(1);
          end
        end
      end
      StLoad: state_d = StExec;
      StExec: begin
        if (fin && !clear) begin
          state_d          = StDone;
          result_d         = exec_res;
          acc_d            = exec_res;
          hist_d[wr_ptr_q] = exec_res;
          wr_ptr_d         = wr_ptr_q + PtrW'(1);
          if (cnt_q != CntFull) cnt_d = cnt_q + CntOne;
          err_d            = err_q | new_err;
          ovf_d            = ovf_q | new_ovf;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Clear aborts from any state; history and op survive.
    if (clear) begin
      state_d  = StIdle;
      acc_d    = '0;
      result_d = '0;
      err_d    = 1'b0;
      ovf_d    = 1'b0;
    end
  end

  // State and datapath registers; operands are captured at the end of LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OP_ADD;
      lop_q    <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      hist_q   <= '{default: '0};
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      hist_q   <= hist_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      if (state_q == StLoad) begin
        a_q   <= a_load;
        b_q   <= b_load;
        lop_q <= op_q;
        sgn_q <= sign_i;
      end
    end
  end

  assign op_o     = op_q;
  assign busy_o   = (state_q == StLoad) || (state_q == StExec);
  assign done_o   = (state_q == StDone);
  assign result_o = result_q;
  assign err_o    = err_q;
  assign ovf_o    = ovf_q;
  assign led_o    = err_q | ovf_q;

endmodule

// File: tb/tb_calc_engine.sv
// Bench for calc_engine (DATA_W=4, HIST_DEPTH=4): directed scenarios plus randomized
// ops checked against an arithmetic reference model.
module tb_calc_engine;

  localparam int HD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic [3:0] btn;
  logic       chain, sgn;
  logic [2:0] op_o;
  logic       busy_o, done_o, err_o, ovf_o, led_o;
  logic [7:0] result_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_op;
  logic [7:0] m_acc, m_res;
  logic       m_err, m_ovf;
  logic [7:0] hq[$];
  int         m_k;

  always #5 clk = ~clk;

  calc_engine #(
    .DATA_W     (4),
    .HIST_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_i     (sw),
    .btn_i    (btn),
    .chain_i  (chain),
    .sign_i   (sgn),
    .op_o     (op_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .err_o    (err_o),
    .ovf_o    (ovf_o),
    .led_o    (led_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic meaning of each op on 4-bit operands.
  function automatic void model(input int op, input logic [3:0] a, input logic [3:0] b,
                                input logic s, output logic [7:0] res, output logic dz,
                                output logic ov);
    int ai, bi, v, q, r, rs;
    ai = s ? int'($signed(a)) : int'(a);
    bi = s ? int'($signed(b)) : int'(b);
    dz = 1'b0;
    ov = 1'b0;
    res = 8'h00;
    case (op)
      0: begin v = ai + bi; res = s ? 8'(v) : 8'(v & 31); end
      1: begin v = ai - bi; res = s ? 8'(v) : 8'(v & 31); end
      2: begin v = ai * bi; res = 8'(v); end
      4: res = {4'h0, a & b};
      5: res = {4'h0, a | b};
      6: res = {4'h0, a ^ b};
      7: res = {4'h0, b};
      default: begin
        if (bi == 0) begin
          res = 8'hFF;
          dz  = 1'b1;
        end else begin
          q   = ai / bi;
          r   = ai % bi;
          res = {4'(r), 4'(q)};
          ov  = s && (q > 7 || q < -8);
        end
      end
    endcase
    if (op != 3) begin
      rs = int'($signed(res));
      ov = s ? (rs > 7 || rs < -8) : (res > 8'd15);
    end
  endfunction

  task automatic model_reset();
    m_op = 0; m_acc = 8'h00; m_res = 8'h00; m_err = 1'b0; m_ovf = 1'b0; m_k = 0;
    hq.delete();
  endtask

  task automatic select_op(input int op);
    while (m_op != op) begin
      btn = 4'b0010;
      tick();
      btn = 4'b0000;
      m_op = (m_op + 1) % 8;
    end
  endtask

  task automatic press_clear();
    btn = 4'b1000;
    tick();
    btn = 4'b0000;
    m_acc = 8'h00; m_res = 8'h00; m_err = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic press_recall();
    btn = 4'b0100;
    tick();
    btn = 4'b0000;
    if (hq.size() > 0) begin
      m_res = hq[hq.size() - 1 - m_k];
      m_k   = (m_k + 1) % hq.size();
    end
  endtask

  // Runs one op from IDLE; returns with the DUT in its done cycle (or after timeout).
  task automatic run_op(input int op, input logic [3:0] a, input logic [3:0] b, input logic s,
                        input logic ch, input logic dup, output int lat, output int busy_n);
    logic [3:0] a_eff;
    logic [7:0] r;
    logic       dz, ov;
    select_op(op);
    a_eff = ch ? m_acc[3:0] : a;
    sw = {a, b}; sgn = s; chain = ch;
    btn = 4'b0001;
    tick();
    btn = dup ? 4'b0001 : 4'b0000;
    lat = 1;
    busy_n = (busy_o === 1'b1) ? 1 : 0;
    while (done_o !== 1'b1 && lat < 30) begin
      tick();
      btn = 4'b0000;
      lat++;
      if (busy_o === 1'b1) busy_n++;
    end
    model(op, a_eff, b, s, r, dz, ov);
    m_res = r; m_acc = r; m_err = m_err | dz; m_ovf = m_ovf | ov; m_k = 0;
    hq.push_back(r);
    if (hq.size() > HD) void'(hq.pop_front());
  endtask

  task automatic test_reset();
    rst = 1'b1; sw = 8'h00; btn = 4'b0000; chain = 1'b0; sgn = 1'b0;
    model_reset();
    tick(); tick();
    checks++;
    if ({op_o, busy_o, done_o, result_o, err_o, ovf_o, led_o} !== 16'h0) begin
      errors++;
      $display("FAIL reset_held: got %h want 0000",
               {op_o, busy_o, done_o, result_o, err_o, ovf_o, led_o});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({op_o, busy_o, done_o, result_o, err_o, ovf_o, led_o} !== 16'h0) begin
      errors++;
      $display("FAIL reset_released: got %h want 0000",
               {op_o, busy_o, done_o, result_o, err_o, ovf_o, led_o});
    end
  endtask

  task automatic test_add_ovf();
    int lat, bn;
    run_op(0, 4'd7, 4'd1, 1'b1, 1'b0, 1'b0, lat, bn);
    checks++;
    if (lat != 3 || bn != 2) begin
      errors++;
      $display("FAIL add_latency: got lat %0d busy %0d want 3 2", lat, bn);
    end
    checks++;
    if ({result_o, err_o, ovf_o, led_o} !== {8'h08, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL add_7_1: got res %h err %b ovf %b led %b want 08 0 1 1",
               result_o, err_o, ovf_o, led_o);
    end
    tick();
  endtask

  task automatic test_mul();
    int lat, bn;
    press_clear();
    run_op(2, 4'hD, 4'd5, 1'b1, 1'b0, 1'b0, lat, bn);
    checks++;
    if (lat != 6 || bn != 5) begin
      errors++;
      $display("FAIL mul_latency: got lat %0d busy %0d want 6 5", lat, bn);
    end
    checks++;
    if ({result_o, ovf_o} !== {8'hF1, 1'b1}) begin
      errors++;
      $display("FAIL mul_m3_5: got res %h ovf %b want f1 1", result_o, ovf_o);
    end
    tick();
  endtask

  task automatic test_div();
    int lat, bn;
    press_clear();
    run_op(3, 4'h9, 4'd2, 1'b1, 1'b0, 1'b0, lat, bn);
    checks++;
    if (lat != 6 || {result_o, err_o, ovf_o} !== {8'hFD, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL div_m7_2: got lat %0d res %h err %b ovf %b want 6 fd 0 0",
               lat, result_o, err_o, ovf_o);
    end
    tick();
    run_op(3, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, lat, bn);
    checks++;
    if ({result_o, err_o, led_o} !== {8'hFF, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL div_by_zero: got res %h err %b led %b want ff 1 1",
               result_o, err_o, led_o);
    end
    tick();
  endtask

  task automatic test_chain();
    int lat, bn, extra;
    press_clear();
    run_op(0, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0, lat, bn);
    checks++;
    if (result_o !== 8'h05) begin
      errors++;
      $display("FAIL chain_first: got %h want 05", result_o);
    end
    tick();
    run_op(0, 4'hA, 4'd4, 1'b0, 1'b1, 1'b1, lat, bn);
    checks++;
    if (result_o !== 8'h09 || lat != 3) begin
      errors++;
      $display("FAIL chain_add: got res %h lat %0d want 09 3", result_o, lat);
    end
    chain = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done_o === 1'b1 || busy_o === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL exec_while_busy: got %0d busy/done cycles after op want 0", extra);
    end
  endtask

  task automatic test_history();
    int lat, bn;
    logic [7:0] exp_seq [5];
    exp_seq = '{8'h05, 8'h04, 8'h03, 8'h02, 8'h05};
    press_clear();
    for (int i = 1; i <= 5; i++) begin
      run_op(7, 4'h0, 4'(i), 1'b0, 1'b0, 1'b0, lat, bn);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      press_recall();
      checks++;
      if (result_o !== exp_seq[i] || result_o !== m_res) begin
        errors++;
        $display("FAIL recall_%0d: got %h want %h", i, result_o, exp_seq[i]);
      end
    end
    run_op(0, 4'hC, 4'h0, 1'b0, 1'b1, 1'b0, lat, bn);
    checks++;
    if (result_o !== 8'h05) begin
      errors++;
      $display("FAIL acc_after_recall: got %h want 05", result_o);
    end
    chain = 1'b0;
    tick();
  endtask

  task automatic test_clear_mid_mul();
    int lat, bn, dn;
    run_op(0, 4'd7, 4'd1, 1'b1, 1'b0, 1'b0, lat, bn);
    tick();
    select_op(2);
    sw = {4'd6, 4'd7}; sgn = 1'b0; chain = 1'b0;
    btn = 4'b0001;
    tick();
    btn = 4'b0000;
    m_k = 0;
    tick();
    btn = 4'b1000;
    tick();
    btn = 4'b0000;
    m_acc = 8'h00; m_res = 8'h00; m_err = 1'b0; m_ovf = 1'b0;
    checks++;
    if ({busy_o, done_o, result_o, err_o, ovf_o, led_o} !== 13'h0 || op_o !== 3'd2) begin
      errors++;
      $display("FAIL clear_mid_mul: got busy %b done %b res %h err %b ovf %b op %0d want 0 0 00 0 0 2",
               busy_o, done_o, result_o, err_o, ovf_o, op_o);
    end
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_o === 1'b1) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL clear_no_done: got %0d done pulses want 0", dn);
    end
    press_recall();
    checks++;
    if (result_o !== m_res) begin
      errors++;
      $display("FAIL clear_keeps_history: got %h want %h", result_o, m_res);
    end
  endtask

  task automatic test_random();
    int lat, bn, op, exp_lat;
    logic [3:0] a, b;
    logic s, ch;
    press_clear();
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 7));
      a  = 4'($urandom);
      b  = 4'($urandom_range(0, 5) == 0 ? 0 : $urandom);
      s  = 1'($urandom);
      ch = ($urandom_range(0, 3) == 0);
      exp_lat = (op == 2 || (op == 3 && b != 4'h0)) ? 6 : 3;
      run_op(op, a, b, s, ch, 1'b0, lat, bn);
      checks++;
      if (lat != exp_lat || op_o !== 3'(m_op) ||
          {result_o, err_o, ovf_o, led_o} !== {m_res, m_err, m_ovf, m_err | m_ovf}) begin
        errors++;
        $display("FAIL rand_%0d op%0d a=%h b=%h s=%b ch=%b: got lat %0d res %h err %b ovf %b led %b want lat %0d res %h err %b ovf %b led %b",
                 it, op, a, b, s, ch, lat, result_o, err_o, ovf_o, led_o,
                 exp_lat, m_res, m_err, m_ovf, m_err | m_ovf);
      end
      tick();
      chain = 1'b0;
      if ($urandom_range(0, 4) == 0) begin
        press_recall();
        checks++;
        if (result_o !== m_res) begin
          errors++;
          $display("FAIL rand_recall_%0d: got %h want %h", it, result_o, m_res);
        end
      end
      if ($urandom_range(0, 7) == 0) press_clear();
    end
  endtask

  task automatic test_reset_mid_op();
    select_op(3);
    sw = {4'hB, 4'd3}; sgn = 1'b1; chain = 1'b0;
    btn = 4'b0001;
    tick();
    btn = 4'b0000;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({op_o, busy_o, done_o, result_o, err_o, ovf_o, led_o} !== 16'h0) begin
      errors++;
      $display("FAIL async_reset_mid_div: got %h want 0000",
               {op_o, busy_o, done_o, result_o, err_o, ovf_o, led_o});
    end
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    press_recall();
    checks++;
    if (result_o !== 8'h00 || op_o !== 3'd0) begin
      errors++;
      $display("FAIL recall_empty: got res %h op %0d want 00 0", result_o, op_o);
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_mul();
    test_div();
    test_chain();
    test_history();
    test_clear_mid_mul();
    test_random();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
